// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel's thread count into blocks and hands them to idle compute cores
module block_dispatcher #(
    parameter int NUM_CORES = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TW = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              thread_count,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [NUM_CORES*8-1:0]  core_block_id,
    output logic [NUM_CORES*TW-1:0] core_thread_count,
    output logic                    done
);
    localparam int SH = $clog2(THREADS_PER_BLOCK);
    localparam logic [8:0] TPB9 = 9'(THREADS_PER_BLOCK);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] tc_q, total, dispatched, completed, disp_nx, comp_nx;
    logic [8:0] round_up;
    logic [NUM_CORES-1:0] assign_en, finish_en;
    logic [7:0] blk_id [NUM_CORES];
    logic [TW-1:0] blk_thr [NUM_CORES];
    logic [8:0] remain [NUM_CORES];
    // nine bits so that 255 + (TPB-1) cannot wrap before the divide
    assign round_up = {1'b0, thread_count} + TPB9 - 9'd1;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (thread_count != 8'd0) ? RUN : DONE;
            RUN: if (completed == total) state_nx = DONE;
            DONE: if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // ascending scan: each idle core claims the next block id in turn
    always_comb begin
        disp_nx = dispatched;
        comp_nx = completed;
        assign_en = '0;
        finish_en = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            blk_id[i] = disp_nx;
            remain[i] = {1'b0, tc_q} - ({1'b0, disp_nx} << SH);
            blk_thr[i] = (remain[i] >= TPB9) ? TW'(THREADS_PER_BLOCK) : remain[i][TW-1:0];
            assign_en[i] = state == RUN && core_reset[i] && disp_nx < total;
            finish_en[i] = state == RUN && core_start[i] && core_done[i];
            disp_nx = disp_nx + 8'(assign_en[i]);
            comp_nx = comp_nx + 8'(finish_en[i]);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_q <= '0;
            total <= '0;
            dispatched <= '0;
            completed <= '0;
            core_start <= '0;
            core_reset <= '1;
            core_block_id <= '0;
            core_thread_count <= '0;
        end else begin
            dispatched <= disp_nx;
            completed <= comp_nx;
            if (state == IDLE && start) begin
                tc_q <= thread_count;
                total <= 8'(round_up >> SH);
                dispatched <= '0;
                completed <= '0;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (assign_en[i]) begin
                    core_block_id[8*i +: 8] <= blk_id[i];
                    core_thread_count[TW*i +: TW] <= blk_thr[i];
                    core_reset[i] <= 1'b0;
                    core_start[i] <= 1'b1;
                end else if (finish_en[i] || state != RUN) begin
                    core_start[i] <= 1'b0;
                    core_reset[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: directed launches checked against a block-level model of the dispatcher
module tb_block_dispatcher;
    localparam int NC = 2, TPB = 4, TW = 3;
    logic clk = 0, reset = 1, start = 0;
    logic [7:0] thread_count = 0;
    logic [NC-1:0] core_done, emu_done = '0, man_done = '0;
    logic [NC-1:0] core_start, core_reset;
    logic [NC*8-1:0] core_block_id;
    logic [NC*TW-1:0] core_thread_count;
    logic done;
    assign core_done = emu_done | man_done;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .TW(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
        .core_block_id(core_block_id), .core_thread_count(core_thread_count), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0, nmis = 0;
    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: kernel phase 0=idle 1=running 2=finished, plus which core holds which block
    int m_st = 0, m_tc = 0, m_total = 0, m_nb = 0, m_comp = 0;
    bit m_busy [NC] = '{0, 0};
    bit m_free [NC];
    int m_id [NC], m_thr [NC];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_nb = 0; m_comp = 0;
            for (int i = 0; i < NC; i++) m_busy[i] = 0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_tc = thread_count;
                    m_total = (m_tc + TPB - 1) / TPB;
                    m_nb = 0; m_comp = 0;
                    m_st = (m_tc != 0) ? 1 : 2;
                end
                1: if (m_comp == m_total) m_st = 2;
                else begin
                    for (int i = 0; i < NC; i++) m_free[i] = !m_busy[i];
                    for (int i = 0; i < NC; i++)
                        if (m_busy[i] && core_done[i]) begin m_busy[i] = 0; m_comp++; end
                    for (int i = 0; i < NC; i++)
                        if (m_free[i] && m_nb < m_total) begin
                            m_busy[i] = 1;
                            m_id[i] = m_nb;
                            m_thr[i] = (m_tc - m_nb * TPB >= TPB) ? TPB : m_tc - m_nb * TPB;
                            m_nb++;
                        end
                end
                default: if (!start) m_st = 0;
            endcase
        end
    end

    // cores that finish a block lat[i] cycles after being started
    bit emu_en = 0;
    int lat [NC] = '{1, 1};
    int cnt [NC] = '{0, 0};
    always @(negedge clk)
        for (int i = 0; i < NC; i++)
            if (emu_en && core_start[i]) begin
                cnt[i]++;
                emu_done[i] = (cnt[i] == lat[i]);
            end else begin
                cnt[i] = 0;
                emu_done[i] = 0;
            end

    int seen [256], thr_seen [256];
    int done_rises = 0;
    logic [NC-1:0] prev_start = '0;
    logic prev_done = 0;
    always @(negedge clk) begin
        chk("done", done, int'(m_st == 2));
        for (int i = 0; i < NC; i++) begin
            chk("core_start", core_start[i], m_busy[i]);
            chk("core_reset", core_reset[i], !m_busy[i]);
            if (m_busy[i]) begin
                chk("block_id", core_block_id[8*i +: 8], m_id[i]);
                chk("thread_cnt", core_thread_count[TW*i +: TW], m_thr[i]);
            end
            if (core_start[i] && !prev_start[i]) begin
                seen[core_block_id[8*i +: 8]]++;
                thr_seen[core_block_id[8*i +: 8]] = core_thread_count[TW*i +: TW];
            end
        end
        if (done && !prev_done) done_rises++;
        prev_start = core_start;
        prev_done = done;
    end

    task automatic clear_log();
        for (int k = 0; k < 256; k++) begin seen[k] = 0; thr_seen[k] = 0; end
        done_rises = 0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin @(negedge clk); n++; end
        chk("wait_done", done, 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_start"}, core_start, 0);
        chk({nm, "_reset"}, core_reset, 3);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_id"}, core_block_id, 0);
        chk({nm, "_thr"}, core_thread_count, 0);
    endtask

    initial begin
        int bad;
        clear_log();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 0;
        // basic split: 10 threads -> blocks of 4, 4, 2
        thread_count = 10; start = 1;
        @(negedge clk);
        @(negedge clk);
        chk("basic_ids", core_block_id, 16'h0100);
        chk("basic_thr", core_thread_count, 6'b100_100);
        man_done = 2'b01;
        @(negedge clk);
        chk("basic_free", core_start, 2'b10);
        man_done = 2'b00;
        @(negedge clk);
        chk("basic_blk2_id", core_block_id[7:0], 2);
        chk("basic_blk2_thr", core_thread_count[2:0], 2);
        man_done = 2'b11;
        @(negedge clk);
        man_done = 2'b00;
        chk("basic_not_yet", done, 0);
        @(negedge clk);
        chk("basic_done", done, 1);
        start = 0;
        @(negedge clk);
        chk("basic_idle", done, 0);
        // zero threads
        thread_count = 0; start = 1;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_nostart", core_start, 0);
        start = 0;
        @(negedge clk);
        chk("zero_idle", done, 0);
        // max count, both cores finishing on the same edge
        clear_log();
        emu_en = 1; lat[0] = 1; lat[1] = 1;
        thread_count = 255; start = 1;
        wait_done(400);
        start = 0;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 64; k++) if (seen[k] != 1) bad++;
        chk("max_ids", bad, 0);
        chk("max_last_thr", thr_seen[63], 3);
        chk("max_no_extra", seen[64], 0);
        chk("max_done_once", done_rises, 1);
        // input isolation and stray core_done
        clear_log();
        lat[0] = 3; lat[1] = 2;
        thread_count = 9; start = 1;
        @(negedge clk);
        thread_count = 1; start = 0; man_done = 2'b11;
        @(negedge clk);
        man_done = 2'b00;
        wait_done(100);
        @(negedge clk);
        chk("iso_blocks", seen[0] + seen[1] + seen[2], 3);
        chk("iso_no_blk3", seen[3], 0);
        chk("iso_last_thr", thr_seen[2], 1);
        // async reset mid-run
        lat[0] = 4; lat[1] = 4;
        thread_count = 255; start = 1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1;
        #1 emu_en = 0;
        chk_reset_vals("arst");
        @(negedge clk);
        reset = 0; start = 0;
        @(negedge clk);
        thread_count = 6; start = 1;
        @(negedge clk);
        @(negedge clk);
        chk("arst_ids", core_block_id, 16'h0100);
        chk("arst_thr", core_thread_count, 6'b010_100);
        man_done = 2'b11;
        @(negedge clk);
        man_done = 2'b00;
        wait_done(10);
        start = 0;
        @(negedge clk);
        // held start: no relaunch until start drops
        clear_log();
        emu_en = 1; lat[0] = 2; lat[1] = 2;
        thread_count = 4; start = 1;
        wait_done(50);
        repeat (5) @(negedge clk);
        chk("held_done", done, 1);
        chk("held_single", seen[0], 1);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        chk("held_idle", done, 0);
        thread_count = 8; start = 1;
        @(negedge clk);
        wait_done(50);
        @(negedge clk);
        chk("held_relaunch", seen[1], 1);
        chk("held_blk0_twice", seen[0], 2);
        start = 0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/block_dispatcher.md
# block_dispatcher

Consumes the kernel thread count held in the device control register and turns it into per-core block assignments. On a kernel start it latches `thread_count`, splits it into blocks of `THREADS_PER_BLOCK`, hands blocks to idle compute cores and tracks their completion. It raises `done` when every block has finished. It sits between the device control register / host start logic and the array of compute cores.

## Interface
- `NUM_CORES`, default 2: number of compute cores driven.
- `THREADS_PER_BLOCK`, default 4: threads per block, a power of two with a maximum of 128.
- `TW`, default `$clog2(THREADS_PER_BLOCK)+1`: width of the per-core thread-count field.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  kernel launch level from host.
- `thread_count`  in  8  total threads in the kernel, from the device control register.
- `core_done`  in  NUM_CORES  per-core block-complete level.
- `core_start`  out  NUM_CORES  per-core "block assigned, run".
- `core_reset`  out  NUM_CORES  per-core "idle / hold in reset".
- `core_block_id`  out  NUM_CORES*8  block index for core i, in bits [8i+7:8i].
- `core_thread_count`  out  NUM_CORES*TW  active threads for core i's block.
- `done`  out  1  kernel complete.

## Operation
- **States.**
  - IDLE: waits for `start`.
  - RUN: dispatches blocks and counts completions.
  - DONE: holds `done` high.
- **Latching.** `total_blocks = ceil(thread_count / THREADS_PER_BLOCK)`, computed with a 9-bit intermediate (255+127 must not overflow) and held in a register. `thread_count` is latched only on the IDLE→RUN or IDLE→DONE transition. Later changes are ignored until the next launch.
- **IDLE transitions.**
  - `start=1` and `thread_count!=0`: latch `thread_count`, clear `dispatched` and `completed`, go to RUN.
  - `start=1` and `thread_count==0`: go directly to DONE.
- **Dispatch (RUN, every edge).** Cores are scanned in ascending index. Each core with `core_reset[i]=1` takes the next block while `dispatched < total_blocks`. Several cores may be dispatched on the same edge. For each dispatched core:
  - `core_block_id[i] <= dispatched`.
  - `core_thread_count[i] <= THREADS_PER_BLOCK`, or `thread_count - dispatched*THREADS_PER_BLOCK` for the final partial block.
  - `core_reset[i] <= 0`, `core_start[i] <= 1`.
  - `dispatched` increments by the number of cores assigned.
- **Completion (RUN).** When `core_done[i]=1` and `core_start[i]=1` at an edge:
  - `core_start[i] <= 0`, `core_reset[i] <= 1`, `completed` increments.
  - Several cores may complete on the same edge; all are counted.
  - `core_done` from a core whose `core_start` is 0 is ignored.
- **Re-dispatch.** A core freed on edge N is eligible for a new block on edge N+1, never on edge N itself.
- **RUN→DONE.** Occurs on the edge where the registered `completed == total_blocks`.
- **DONE.** `done=1`, all `core_reset=1`, all `core_start=0`. Goes to IDLE when `start=0`. While `start` stays high the block remains in DONE, so there is no relaunch.
- **start in RUN.** Deasserting `start` during RUN is ignored; the kernel runs to completion.
- **core_reset in IDLE.** `core_reset` is all ones in IDLE.

## Timing
- **Reset values (asynchronous, immediate):**
  - State IDLE, `done=0`.
  - `core_start` = 0, `core_reset` = all ones.
  - `core_block_id` = 0, `core_thread_count` = 0.
  - `dispatched` = 0, `completed` = 0.
- **Reset mid-RUN:** outputs return to the reset values immediately, in-flight blocks are abandoned, and the next launch starts from block 0.
- **Launch latency:** `start` is sampled at edge E0 (IDLE→RUN). The first `core_start` is high after E1. `block_id` and `thread_count` are valid in the same cycle as `core_start`.
- **Zero-thread kernel:** `done` is high after E0; `core_start` never rises.
- **Completion latency:** the last `core_done` is sampled at edge Ec, `completed` reaches total after Ec, and `done` is high after Ec+1.
- **Output registration:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic split:** `thread_count=10`, TPB=4, 2 cores.
  - After E1: core0 has block 0 / 4 threads, core1 has block 1 / 4 threads.
  - core0 done → next cycle core0 is reset, the cycle after it gets block 2 / 2 threads.
  - `done` follows all three completions.
- **Zero threads:** `thread_count=0`, pulse `start` → `done=1` one cycle later, no `core_start` ever asserted. Drop `start` → IDLE, `done=0`.
- **Max count:** `thread_count=255` → 64 blocks dispatched with ids 0..63, and block 63 carries 3 threads. Simultaneous `core_done` on both cores is counted twice. `done` asserts exactly once.
- **Input isolation:** change `thread_count` to 1 and drop `start` mid-RUN → dispatch still follows the latched value and the kernel completes. A stray `core_done` on an unstarted core does not increment `completed`.
- **Async reset mid-RUN:** assert `reset` between clock edges → outputs are at reset values before the next edge. A relaunch with `thread_count=6` gives blocks 0 (4 threads) and 1 (2 threads).
- **Held start:** `start` held high through DONE → stays in DONE with no second launch. Deassert then reassert `start` → a new kernel launches.
